// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, control-bit indices and occupancy constants for pipeline latches
package pipe_pkg;
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;
    localparam int CTRL_REGWRITE = 2;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_WRITE_PC = 0;
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;
    function automatic logic [1:0] occ_of(input state_t s);
        return (s == ST_SKID) ? OCC_TWO : (s == ST_FULL) ? OCC_ONE : OCC_EMPTY;
    endfunction
endpackage

// File: rtl/pipe_slot_reg.sv
// pipe_slot_reg: one load-enabled payload slot whose control field can be cleared to a no-op
module pipe_slot_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 101,
    parameter int CTRL_W = 3,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);
    // clear beats load and leaves data alone: a no-op control makes the payload don't-care
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            data <= '0;
            ctrl <= CTRL_NOP;
        end else if (clear)
            ctrl <= CTRL_NOP;
        else if (load) begin
            data <= in_data;
            ctrl <= in_ctrl;
        end
endmodule

// File: rtl/pipe_stage_latch.sv
// pipe_stage_latch: handshaked pipeline-boundary register with optional skid slot, flush and step gate
module pipe_stage_latch
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 101,
    parameter int CTRL_W  = 3,
    parameter int SKID_EN = 1,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_step,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [1:0]        o_occupancy
);
    state_t            state, state_nxt;
    logic              push, pop, clear, main_load, skid_load;
    logic [DATA_W-1:0] main_data, skid_data, main_in_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_in_ctrl;

    assign o_valid     = state != ST_EMPTY;
    assign o_ctrl      = o_valid ? main_ctrl : CTRL_NOP;
    assign o_data      = main_data;
    assign o_occupancy = occ_of(state);
    assign o_ready     = i_step & ~i_flush &
                         ((SKID_EN != 0) ? (state != ST_SKID) : (state == ST_EMPTY || i_ready));
    assign push        = i_valid & o_ready;
    assign pop         = o_valid & i_ready & i_step;
    assign clear       = i_step & i_flush;
    assign main_in_data = (state == ST_SKID) ? skid_data : i_data;
    assign main_in_ctrl = (state == ST_SKID) ? skid_ctrl : i_ctrl;

    // next state and slot load strobes; push and pop already carry the step gate
    always_comb begin
        state_nxt = state;
        main_load = 1'b0;
        skid_load = 1'b0;
        if (clear)
            state_nxt = ST_EMPTY;
        else
            case (state)
                ST_EMPTY: begin
                    main_load = push;
                    state_nxt = push ? ST_FULL : ST_EMPTY;
                end
                ST_FULL: begin
                    main_load = push & pop;
                    skid_load = push & ~pop;
                    state_nxt = (push & ~pop) ? ST_SKID : (~push & pop) ? ST_EMPTY : ST_FULL;
                end
                ST_SKID: begin
                    main_load = pop;
                    state_nxt = pop ? ST_FULL : ST_SKID;
                end
                default: state_nxt = ST_EMPTY;
            endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            state <= ST_EMPTY;
        else
            state <= state_nxt;

    pipe_slot_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_NOP(CTRL_NOP)) u_main (
        .clk(clk), .rst(rst), .load(main_load), .clear(clear),
        .in_data(main_in_data), .in_ctrl(main_in_ctrl), .data(main_data), .ctrl(main_ctrl)
    );

    generate
        if (SKID_EN != 0) begin : g_skid
            pipe_slot_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_NOP(CTRL_NOP)) u_skid (
                .clk(clk), .rst(rst), .load(skid_load), .clear(clear),
                .in_data(i_data), .in_ctrl(i_ctrl), .data(skid_data), .ctrl(skid_ctrl)
            );
        end else begin : g_no_skid
            assign skid_data = '0;
            assign skid_ctrl = CTRL_NOP;
        end
    endgenerate

    a_no_push_in_skid: assert property (@(posedge clk) disable iff (!rst) !(push && state == ST_SKID));
    a_occ_matches:     assert property (@(posedge clk) disable iff (!rst) o_occupancy == 2'(state));
    a_skid_disabled:   assert property (@(posedge clk) disable iff (!rst) SKID_EN != 0 || state != ST_SKID);
endmodule

// File: tb/tb_pipe_stage_latch.sv
// tb_pipe_stage_latch: queue-model scoreboard bench for the skid and non-skid latch builds
module tb_pipe_stage_latch;
    localparam int DW = 101;
    localparam int CW = 3;
    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0, rst = 1'b0;
    logic          i_step = 1'b0, i_flush = 1'b0, i_valid = 1'b0, i_ready = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic [CW-1:0] i_ctrl = '0;
    logic          o_ready, o_valid, o_ready0, o_valid0;
    logic [DW-1:0] o_data, o_data0;
    logic [CW-1:0] o_ctrl, o_ctrl0;
    logic [1:0]    o_occupancy, o_occupancy0;

    ent_t exp_q[$];
    int   n_checks = 0, n_fail = 0, model_cnt = 0;
    logic model_ready = 1'b0, prev_flush = 1'b0, mon_en = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_latch #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1), .CTRL_NOP(3'b000)) dut (
        .clk(clk), .rst(rst), .i_step(i_step), .i_flush(i_flush), .i_valid(i_valid),
        .o_ready(o_ready), .i_data(i_data), .i_ctrl(i_ctrl), .o_valid(o_valid),
        .i_ready(i_ready), .o_data(o_data), .o_ctrl(o_ctrl), .o_occupancy(o_occupancy)
    );

    pipe_stage_latch #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(0), .CTRL_NOP(3'b000)) dut0 (
        .clk(clk), .rst(rst), .i_step(i_step), .i_flush(i_flush), .i_valid(i_valid),
        .o_ready(o_ready0), .i_data(i_data), .i_ctrl(i_ctrl), .o_valid(o_valid0),
        .i_ready(i_ready), .o_data(o_data0), .o_ctrl(o_ctrl0), .o_occupancy(o_occupancy0)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rdata();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    // issue one cycle of stimulus and record what the latch must eventually emit
    task automatic cyc(input logic st, input logic fl, input logic v, input logic r,
                       input logic [DW-1:0] d, input logic [CW-1:0] c);
        if (prev_flush) exp_q.delete();
        i_step = st; i_flush = fl; i_valid = v; i_ready = r; i_data = d; i_ctrl = c;
        model_cnt   = exp_q.size();
        model_ready = st & ~fl & (model_cnt < 2);
        if (v && model_ready) exp_q.push_back({c, d});
        prev_flush = st & fl;
        @(posedge clk);
        #1;
    endtask

    // monitor: mid-cycle comparison of flags and of every head entry taken downstream
    always @(negedge clk)
        if (mon_en) begin
            chk("occupancy", 128'(o_occupancy), 128'(model_cnt));
            chk("o_valid", 128'(o_valid), 128'(model_cnt != 0));
            chk("o_ready", 128'(o_ready), 128'(model_ready));
            if (model_cnt == 0) chk("ctrl_nop_when_idle", 128'(o_ctrl), 128'(0));
            if (model_cnt != 0 && i_ready && i_step) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_underflow: head taken with empty scoreboard at %0t", $time);
                end else begin
                    ent_t e;
                    e = exp_q.pop_front();
                    chk("head_data", 128'(o_data), 128'(e.d));
                    chk("head_ctrl", 128'(o_ctrl), 128'(e.c));
                end
            end
            chk("noskid_occ_lt2", 128'(o_occupancy0 != 2'd2), 128'(1));
            chk("noskid_ready_rule", 128'(o_ready0),
                128'(i_step & ~i_flush & (o_occupancy0 == 2'd0 || i_ready)));
        end

    initial begin
        #2;
        chk("reset_valid", 128'(o_valid), 128'(0));
        chk("reset_occ", 128'(o_occupancy), 128'(0));
        chk("reset_ctrl", 128'(o_ctrl), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (300)
            cyc($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 70,
                $urandom_range(0, 99) < 60, rdata(), 3'($urandom));
        cyc(1, 1, 0, 1, '0, '0);
        for (int k = 1; k <= 8; k++) cyc(1, 0, 1, 1, DW'(k), 3'b001);
        cyc(1, 0, 0, 1, '0, '0);
        cyc(1, 0, 0, 1, '0, '0);
        cyc(1, 0, 1, 0, DW'(5), 3'b010);
        cyc(1, 0, 1, 0, DW'(6), 3'b011);
        cyc(1, 0, 0, 0, '0, '0);
        repeat (3) cyc(1, 0, 0, 1, '0, '0);
        cyc(1, 0, 1, 0, DW'(7), 3'b111);
        cyc(1, 0, 1, 0, DW'(8), 3'b111);
        cyc(1, 1, 1, 0, DW'(9), 3'b111);
        cyc(1, 0, 0, 0, '0, '0);
        cyc(1, 0, 1, 0, DW'(10), 3'b101);
        repeat (4) cyc(0, 1, 1, 1, DW'(11), 3'b101);
        repeat (3) cyc(1, 0, 0, 1, '0, '0);
        cyc(1, 0, 1, 1, DW'(12), 3'b001);
        chk("noskid_full", 128'(o_occupancy0), 128'(1));
        i_ready = 1'b0;
        #1;
        chk("noskid_ready_drops_same_cycle", 128'(o_ready0), 128'(0));
        i_ready = 1'b1;
        #1;
        chk("noskid_ready_rises_same_cycle", 128'(o_ready0), 128'(1));
        cyc(1, 0, 0, 1, '0, '0);
        cyc(1, 0, 1, 0, DW'(13), 3'b111);
        cyc(1, 0, 1, 0, DW'(14), 3'b110);
        chk("pre_reset_occ", 128'(o_occupancy), 128'(2));
        mon_en = 1'b0;
        i_step = 1'b0;
        i_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_valid", 128'(o_valid), 128'(0));
        chk("async_reset_ctrl", 128'(o_ctrl), 128'(0));
        chk("async_reset_occ", 128'(o_occupancy), 128'(0));
        chk("async_reset_occ_noskid", 128'(o_occupancy0), 128'(0));
        exp_q.delete();
        prev_flush = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b1;
        cyc(1, 0, 1, 1, DW'(15), 3'b010);
        cyc(1, 0, 0, 1, '0, '0);
        cyc(1, 0, 0, 1, '0, '0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
